// File: rtl/fft_sequencer.sv
// fft_sequencer: address/control sequencer for an in-place radix-2 DIT FFT over bit-reversed RAM.
// Optional FFT_SEQ_HOLD_EN adds a 'hold' input that stalls the READ state.
`default_nettype none

module fft_sequencer #(
  parameter int N      = 32,
  parameter int BF_LAT = 2,
  parameter int LOGN   = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [LOGN-1:0] address1,
  output logic [LOGN-1:0] address2,
  output logic            sel,
  output logic            wr_en,
  output logic            bf_en,
  output logic [LOGN-2:0] tw_idx,
  output logic [LOGN-1:0] stage,
  output logic            busy,
  output logic            done
`ifdef FFT_SEQ_HOLD_EN
  ,
  input  logic            hold
`endif
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

  localparam logic [LOGN-2:0] K_LAST     = '1;
  localparam logic [LOGN-1:0] STAGE_LAST = LOGN'(LOGN - 1);
  localparam logic [2:0]      WAIT_LAST  = 3'(BF_LAT - 1);

  state_t          state, state_nx;
  logic [LOGN-2:0] k;
  logic [LOGN-1:0] stage_cnt;
  logic [2:0]      wait_cnt;
  logic            read_hold;
  logic            last_bfly;

`ifdef FFT_SEQ_HOLD_EN
  assign read_hold = hold;
`else
  assign read_hold = 1'b0;
`endif

  assign last_bfly = (k == K_LAST) && (stage_cnt == STAGE_LAST);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = READ;
      READ:    if (!read_hold) state_nx = WAIT;
      WAIT:    if (wait_cnt == WAIT_LAST) state_nx = WRITE;
      WRITE:   state_nx = last_bfly ? DONE : READ;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sel   = ((state == READ) && !read_hold) || (state == WRITE);
    wr_en = (state == WRITE);
    bf_en = (state == WAIT) && (wait_cnt == 3'd0);
    busy  = (state == READ) || (state == WAIT) || (state == WRITE);
    done  = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      stage_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= (state == WAIT) ? wait_cnt + 3'd1 : 3'd0;
      if (state == WRITE) begin
        if (k == K_LAST) begin
          k         <= '0;
          stage_cnt <= (stage_cnt == STAGE_LAST) ? '0 : stage_cnt + LOGN'(1);
        end else begin
          k <= k + (LOGN-1)'(1);
        end
      end
    end
  end

  // address1 is k with a zero bit inserted at position 'stage'; address2 sets that bit.
  logic [LOGN-1:0] kx, span, low_mask, pos, top, tw_full;

  always_comb begin
    kx       = {1'b0, k};
    span     = LOGN'(1) << stage_cnt;
    low_mask = span - LOGN'(1);
    pos      = kx & low_mask;
    top      = ((kx & ~low_mask) << 1) | pos;
    tw_full  = pos << (STAGE_LAST - stage_cnt);
    address1 = busy ? top : '0;
    address2 = busy ? (top | span) : '0;
    tw_idx   = busy ? tw_full[LOGN-2:0] : '0;
    stage    = busy ? stage_cnt : '0;
  end

endmodule

`default_nettype wire

// File: doc/fft_sequencer.md
FFT_SEQUENCER -- requirements
Module: fft_sequencer

Interface
REQ-001 SHALL have parameter N, default 32, meaning FFT points, a power of 2, 4..1024.
REQ-002 SHALL have parameter BF_LAT, default 2, meaning cycles from bf_en to butterfly result valid, 1..8.
REQ-003 SHALL have parameter LOGN, default $clog2(N), meaning stage count and address width.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  pulse that starts one full FFT pass; sampled only in IDLE.
REQ-007 SHALL have port address1  output  LOGN  RAM port-1 address, the butterfly top operand.
REQ-008 SHALL have port address2  output  LOGN  RAM port-2 address, the butterfly bottom operand.
REQ-009 SHALL have port sel  output  1  RAM access enable.
REQ-010 SHALL have port wr_en  output  1  RAM write when high with sel, read when low with sel.
REQ-011 SHALL have port bf_en  output  1  butterfly operand-capture strobe.
REQ-012 SHALL have port tw_idx  output  LOGN-1  twiddle ROM index, W_N^tw_idx.
REQ-013 SHALL have port stage  output  LOGN  current stage number.
REQ-014 SHALL have port busy  output  1  pass in progress.
REQ-015 SHALL have port done  output  1  one-cycle pass-complete pulse.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WAIT, WRITE, DONE; radix-2 in-place DIT FFT; RAM contents are in bit-reversed order before start.
REQ-017 SHALL move IDLE->READ on the edge where start=1; start is ignored in every other state.
REQ-018 SHALL drive sel=1 and wr_en=0 in READ, then enter WAIT.
REQ-019 SHALL assert bf_en for exactly the first cycle after READ, the cycle RAM read data is valid.
REQ-020 SHALL stay in WAIT for BF_LAT cycles, with sel=0, then enter WRITE.
REQ-021 SHALL drive sel=1 and wr_en=1 for one cycle in WRITE, to the same addresses as the preceding READ.
REQ-022 SHALL, after WRITE, advance butterfly counter k (0..N/2-1) and go to READ; when k wraps, increment stage; after WRITE of stage LOGN-1, k=N/2-1, go to DONE.
REQ-023 SHALL compute per stage s and butterfly k: span=2^s, pos=k mod span, address1=(k>>s)*2*span+pos, address2=address1+span, tw_idx=pos<<(LOGN-1-s).
REQ-024 SHALL hold address1, address2, tw_idx and stage stable from READ through WRITE of the same butterfly.
REQ-025 SHALL take BF_LAT+2 cycles per butterfly, for a pass length of LOGN*(N/2)*(BF_LAT+2) cycles.
REQ-026 SHALL assert busy from the first READ through the final WRITE inclusive.
REQ-027 SHALL pulse done for the single DONE cycle, then return to IDLE; start in the DONE cycle is ignored.
REQ-028 SHALL never assert sel in IDLE, WAIT or DONE.

Reset
REQ-029 SHALL, on rst=1, go to IDLE immediately and clear k and stage.
REQ-030 SHALL, on rst=1, drive all outputs to 0 (address1, address2, sel, wr_en, bf_en, tw_idx, stage, busy, done).
REQ-031 SHALL, on reset mid-pass, suppress any pending WRITE; RAM is left partially transformed and is not restored.

Configuration
REQ-032 SHALL, with FFT_SEQ_HOLD_EN defined, add port hold (input, 1 bit).
REQ-033 SHALL, while hold=1 in READ, keep the state in READ with sel=0 and keep k and stage unchanged.
REQ-034 SHALL, under REQ-033, issue the read on the first cycle with hold=0.
REQ-035 SHALL NOT let hold affect WAIT or WRITE.
REQ-036 SHALL, without FFT_SEQ_HOLD_EN, have no hold port and behave as if hold=0.

Verification (N=8, BF_LAT=2)
REQ-037 SHALL cover: start pulse at edge t0 -> READ at t1 with address1=0, address2=1, tw_idx=0; bf_en at t2; WRITE at t4 to (0,1); done pulse at t49; busy high t1..t48.
REQ-038 SHALL cover: full pass -> address pairs are stage 0 (0,1)(2,3)(4,5)(6,7); stage 1 (0,2)(1,3)(4,6)(5,7); stage 2 (0,4)(1,5)(2,6)(3,7).
REQ-039 SHALL cover: full pass -> tw_idx is stage 0 all 0; stage 1 0,2,0,2; stage 2 0,1,2,3.
REQ-040 SHALL cover: start repeated at t10 and at the done cycle -> no restart; busy, addresses and the t49 done are unchanged; a later IDLE start begins a new pass.
REQ-041 SHALL cover: rst=1 during WAIT of stage 1, k=2 -> all outputs 0 at once, no WRITE; next start restarts at stage 0, (0,1).
REQ-042 SHALL cover: FFT_SEQ_HOLD_EN with hold=1 for 3 cycles at the second READ -> address (2,3) is held, sel=0, and done is delayed exactly 3 cycles to t52.
